// File: rtl/store_commit_buffer_pkg.sv
// Shared constants and drain FSM encoding for the post-commit store buffer.
// Optional forwarding logic elsewhere is enabled with the STORE_FWD_EN macro.
package store_commit_buffer_pkg;

    localparam int SCB_NUM  = 4;
    localparam int SCB_SEL  = 2;
    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    typedef enum logic [1:0] {
        SCB_IDLE     = 2'd0,
        SCB_REQ      = 2'd1,
        SCB_WAIT_ACK = 2'd2
    } scb_state_e;

endpackage

// File: rtl/store_commit_buffer_fwd_match.sv
// Youngest-match search over buffered store addresses for load forwarding.
// Compiled only when STORE_FWD_EN is defined; the default build has no compare logic.
`ifdef STORE_FWD_EN
module store_commit_buffer_fwd_match
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH = SCB_NUM,
    parameter int SEL   = SCB_SEL
) (
    input  logic [DEPTH-1:0]               i_valid,
    input  logic [DEPTH-1:0][ADDR_LEN-1:0] i_addr,
    input  logic [SEL-1:0]                 i_tail,
    input  logic [ADDR_LEN-1:0]            i_lookup_addr,
    output logic                           o_hit,
    output logic [SEL-1:0]                 o_sel
);

    logic [SEL-1:0] w_idx;

    // Walk from oldest (at tail when full) to youngest (tail-1); the last match wins.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        w_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - SEL'(k);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_lookup_addr)) begin
                o_hit = 1'b1;
                o_sel = w_idx;
            end
        end
    end

endmodule
`endif

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: in-order queue of retired stores drained to memory via req/ack.
// Define STORE_FWD_EN to enable store-to-load forwarding on the fwd_* outputs.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int SCB_DEPTH = store_commit_buffer_pkg::SCB_NUM,
    parameter int SCB_SEL   = store_commit_buffer_pkg::SCB_SEL
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_commit_valid_1,
    input  logic                i_commit_valid_2,
    input  logic [ADDR_LEN-1:0] i_commit_addr_1,
    input  logic [ADDR_LEN-1:0] i_commit_addr_2,
    input  logic [DATA_LEN-1:0] i_commit_data_1,
    input  logic [DATA_LEN-1:0] i_commit_data_2,
    output logic                o_commit_ready,
    output logic                o_mem_req_valid,
    output logic [ADDR_LEN-1:0] o_mem_req_addr,
    output logic [DATA_LEN-1:0] o_mem_req_data,
    input  logic                i_mem_req_ready,
    input  logic                i_mem_ack,
    input  logic [ADDR_LEN-1:0] i_ld_lookup_addr,
    output logic                o_fwd_hit,
    output logic [DATA_LEN-1:0] o_fwd_data,
    output logic                o_scb_empty,
    output logic [SCB_SEL:0]    o_scb_count,
    output logic                o_overflow_err
);

    localparam logic [SCB_SEL:0] LP_PUSH_LIMIT = (SCB_SEL+1)'(SCB_DEPTH - 2);
    localparam logic [SCB_SEL:0] LP_ONE        = (SCB_SEL+1)'(1);

    logic [SCB_DEPTH-1:0][ADDR_LEN-1:0] r_addr;
    logic [SCB_DEPTH-1:0][DATA_LEN-1:0] r_data;
    logic [SCB_DEPTH-1:0]               r_valid;
    logic [SCB_SEL-1:0]                 r_head;
    logic [SCB_SEL-1:0]                 r_tail;
    logic [SCB_SEL:0]                   r_count;
    logic                               r_overflow;

    scb_state_e                         r_state;
    logic                               r_req_valid;
    logic [ADDR_LEN-1:0]                r_req_addr;
    logic [DATA_LEN-1:0]                r_req_data;

    logic                               w_commit_ready;
    logic                               w_push_any;
    logic                               w_push_ok;
    logic [SCB_SEL:0]                   w_push_cnt;
    logic [SCB_SEL-1:0]                 w_slot2_idx;
    logic                               w_pop;
    logic [SCB_SEL-1:0]                 w_head_next;
    logic [SCB_SEL:0]                   w_count_next;

    assign w_commit_ready = (r_count <= LP_PUSH_LIMIT);
    assign w_push_any     = i_commit_valid_1 | i_commit_valid_2;
    assign w_push_ok      = w_push_any & w_commit_ready;
    assign w_push_cnt     = w_push_ok ? ((SCB_SEL+1)'(i_commit_valid_1) + (SCB_SEL+1)'(i_commit_valid_2))
                                      : '0;
    // A lone slot-2 store takes the tail position itself.
    assign w_slot2_idx    = r_tail + SCB_SEL'(i_commit_valid_1);
    assign w_pop          = (r_state == SCB_WAIT_ACK) && i_mem_ack;
    assign w_head_next    = r_head + SCB_SEL'(w_pop);
    assign w_count_next   = r_count + w_push_cnt - (SCB_SEL+1)'(w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= r_tail + SCB_SEL'(w_push_cnt);
            r_count <= w_count_next;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
            end
            if (w_push_ok && i_commit_valid_1) begin
                r_addr[r_tail]  <= i_commit_addr_1;
                r_data[r_tail]  <= i_commit_data_1;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_push_ok && i_commit_valid_2) begin
                r_addr[w_slot2_idx]  <= i_commit_addr_2;
                r_data[w_slot2_idx]  <= i_commit_data_2;
                r_valid[w_slot2_idx] <= 1'b1;
            end
            if (w_push_any && !w_commit_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // When more entries already sit behind the head, the next request is loaded straight
    // from the ack cycle so the drain sustains one store every two cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= SCB_IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
        end else begin
            case (r_state)
                SCB_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= SCB_REQ;
                    end
                end
                SCB_REQ: begin
                    if (!r_req_valid) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_addr[r_head];
                        r_req_data  <= r_data[r_head];
                    end else if (i_mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= SCB_WAIT_ACK;
                    end
                end
                SCB_WAIT_ACK: begin
                    if (i_mem_ack) begin
                        if (r_count > LP_ONE) begin
                            r_state     <= SCB_REQ;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= r_addr[w_head_next];
                            r_req_data  <= r_data[w_head_next];
                        end else if (w_count_next != '0) begin
                            r_state <= SCB_REQ;
                        end else begin
                            r_state <= SCB_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= SCB_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_commit_ready  = w_commit_ready;
    assign o_mem_req_valid = r_req_valid;
    assign o_mem_req_addr  = r_req_addr;
    assign o_mem_req_data  = r_req_data;
    assign o_scb_empty     = (r_count == '0);
    assign o_scb_count     = r_count;
    assign o_overflow_err  = r_overflow;

`ifdef STORE_FWD_EN
    logic               w_fwd_hit;
    logic [SCB_SEL-1:0] w_fwd_sel;

    store_commit_buffer_fwd_match #(
        .DEPTH (SCB_DEPTH),
        .SEL   (SCB_SEL)
    ) u_fwd_match (
        .i_valid       (r_valid),
        .i_addr        (r_addr),
        .i_tail        (r_tail),
        .i_lookup_addr (i_ld_lookup_addr),
        .o_hit         (w_fwd_hit),
        .o_sel         (w_fwd_sel)
    );

    assign o_fwd_hit  = w_fwd_hit;
    assign o_fwd_data = w_fwd_hit ? r_data[w_fwd_sel] : '0;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_ld_lookup_addr, r_valid};
    assign o_fwd_hit    = 1'b0;
    assign o_fwd_data   = '0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer; expectations follow STORE_FWD_EN if defined.
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0] data;
    } storeT;

    logic                clk = 1'b0;
    logic                i_reset;
    logic                i_commit_valid_1, i_commit_valid_2;
    logic [ADDR_LEN-1:0] i_commit_addr_1, i_commit_addr_2;
    logic [DATA_LEN-1:0] i_commit_data_1, i_commit_data_2;
    logic                o_commit_ready;
    logic                o_mem_req_valid;
    logic [ADDR_LEN-1:0] o_mem_req_addr;
    logic [DATA_LEN-1:0] o_mem_req_data;
    logic                i_mem_req_ready;
    logic                i_mem_ack;
    logic [ADDR_LEN-1:0] i_ld_lookup_addr;
    logic                o_fwd_hit;
    logic [DATA_LEN-1:0] o_fwd_data;
    logic                o_scb_empty;
    logic [SCB_SEL:0]    o_scb_count;
    logic                o_overflow_err;

    storeT sbQ[$];
    int    checkCount    = 0;
    int    passCount     = 0;
    int    modelCount    = 0;
    bit    modelOverflow = 1'b0;
    bit    memReadyEn    = 1'b0;
    bit    autoAck       = 1'b1;
    bit    ackPending    = 1'b0;

    always #5 clk = ~clk;

    store_commit_buffer dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_commit_valid_1 (i_commit_valid_1),
        .i_commit_valid_2 (i_commit_valid_2),
        .i_commit_addr_1  (i_commit_addr_1),
        .i_commit_addr_2  (i_commit_addr_2),
        .i_commit_data_1  (i_commit_data_1),
        .i_commit_data_2  (i_commit_data_2),
        .o_commit_ready   (o_commit_ready),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_data   (o_mem_req_data),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_ack        (i_mem_ack),
        .i_ld_lookup_addr (i_ld_lookup_addr),
        .o_fwd_hit        (o_fwd_hit),
        .o_fwd_data       (o_fwd_data),
        .o_scb_empty      (o_scb_empty),
        .o_scb_count      (o_scb_count),
        .o_overflow_err   (o_overflow_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_count"}, 64'(o_scb_count), 64'(modelCount));
        checkOutput({tag, "_empty"}, 64'(o_scb_empty), 64'(modelCount == 0));
        checkOutput({tag, "_ready"}, 64'(o_commit_ready), 64'(modelCount <= SCB_NUM - 2));
        checkOutput({tag, "_ovf"}, 64'(o_overflow_err), 64'(modelOverflow));
    endtask

    // Drives commit inputs at a falling edge and records what the buffer should accept.
    task automatic driveCommit(input bit v1, input logic [31:0] a1, input logic [31:0] d1,
                               input bit v2, input logic [31:0] a2, input logic [31:0] d2);
        i_commit_valid_1 = v1; i_commit_addr_1 = a1; i_commit_data_1 = d1;
        i_commit_valid_2 = v2; i_commit_addr_2 = a2; i_commit_data_2 = d2;
        if (v1 || v2) begin
            if (modelCount <= SCB_NUM - 2) begin
                if (v1) begin sbQ.push_back({a1, d1}); modelCount++; end
                if (v2) begin sbQ.push_back({a2, d2}); modelCount++; end
            end else begin
                modelOverflow = 1'b1;
            end
        end
    endtask

    task automatic endCycle(input string tag);
        @(negedge clk);
        i_commit_valid_1 = 1'b0;
        i_commit_valid_2 = 1'b0;
        checkState(tag);
    endtask

    task automatic applyStimulus(input string tag, input bit v1, input logic [31:0] a1, input logic [31:0] d1,
                                 input bit v2, input logic [31:0] a2, input logic [31:0] d2);
        driveCommit(v1, a1, d1, v2, a2, d2);
        endCycle(tag);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!o_mem_req_valid && n < 50) begin endCycle(tag); n++; end
        checkOutput({tag, "_req_seen"}, 64'(o_mem_req_valid), 64'd1);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((modelCount != 0 || !o_scb_empty) && n < 200) begin endCycle(tag); n++; end
        checkOutput({tag, "_drained"}, 64'(o_scb_empty), 64'd1);
        checkOutput({tag, "_sb_left"}, 64'(sbQ.size()), 64'd0);
    endtask

    task automatic applyReset();
        i_reset = 1'b1;
        i_commit_valid_1 = 1'b0;
        i_commit_valid_2 = 1'b0;
        @(negedge clk);
        modelCount = 0; modelOverflow = 1'b0; ackPending = 1'b0;
        sbQ.delete();
        checkState("rst");
        checkOutput("rst_req_valid", 64'(o_mem_req_valid), 64'd0);
        checkOutput("rst_req_addr", 64'(o_mem_req_addr), 64'd0);
        checkOutput("rst_req_data", 64'(o_mem_req_data), 64'd0);
        checkOutput("rst_fwd_hit", 64'(o_fwd_hit), 64'd0);
        checkOutput("rst_fwd_data", 64'(o_fwd_data), 64'd0);
        i_reset = 1'b0;
    endtask

    // Memory model: accepts when enabled, checks order against the scoreboard, acks one cycle later.
    initial begin : responder
        storeT expEntry;
        i_mem_req_ready = 1'b0;
        i_mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            i_mem_ack = 1'b0;
            if (ackPending) begin
                i_mem_ack = 1'b1;
                ackPending = 1'b0;
                modelCount--;
            end
            i_mem_req_ready = memReadyEn;
            if (memReadyEn && o_mem_req_valid && !i_reset) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_req", 64'(o_mem_req_addr), 64'hDEAD_0000);
                end else begin
                    expEntry = sbQ.pop_front();
                    checkOutput("mem_addr", 64'(o_mem_req_addr), 64'(expEntry.addr));
                    checkOutput("mem_data", 64'(o_mem_req_data), 64'(expEntry.data));
                end
                if (autoAck) ackPending = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_reset = 1'b1;
        i_commit_valid_1 = 1'b0; i_commit_valid_2 = 1'b0;
        i_commit_addr_1 = '0; i_commit_addr_2 = '0;
        i_commit_data_1 = '0; i_commit_data_2 = '0;
        i_ld_lookup_addr = '0;
        @(negedge clk);
        applyReset();

        // Single commit: request appears two edges after the commit edge.
        memReadyEn = 1'b1;
        applyStimulus("t1", 1, 32'h100, 32'hAA, 0, 0, 0);
        checkOutput("t1_req_n0", 64'(o_mem_req_valid), 64'd0);
        endCycle("t1");
        checkOutput("t1_req_n1", 64'(o_mem_req_valid), 64'd0);
        endCycle("t1");
        checkOutput("t1_req_n2", 64'(o_mem_req_valid), 64'd1);
        checkOutput("t1_req_addr", 64'(o_mem_req_addr), 64'h100);
        checkOutput("t1_req_data", 64'(o_mem_req_data), 64'hAA);
        endCycle("t1");
        endCycle("t1");
        checkOutput("t1_empty_after_ack", 64'(o_scb_empty), 64'd1);

        // Dual commit, drained in slot order.
        applyStimulus("t2", 1, 32'h10, 32'h1, 1, 32'h20, 32'h2);
        checkOutput("t2_count", 64'(o_scb_count), 64'd2);
        waitValid("t2");
        checkOutput("t2_first_addr", 64'(o_mem_req_addr), 64'h10);
        waitDrain("t2");

        // Stalled memory: request held stable for five cycles.
        memReadyEn = 1'b0;
        applyStimulus("t4", 1, 32'h300, 32'h33, 0, 0, 0);
        waitValid("t4");
        for (int i = 0; i < 4; i++) begin
            endCycle("t4");
            checkOutput("t4_hold_valid", 64'(o_mem_req_valid), 64'd1);
            checkOutput("t4_hold_addr", 64'(o_mem_req_addr), 64'h300);
            checkOutput("t4_hold_data", 64'(o_mem_req_data), 64'h33);
        end
        memReadyEn = 1'b1;
        waitDrain("t4");

        // Push and pop on the same edge, then random traffic wrapping the pointers.
        memReadyEn = 1'b0;
        applyStimulus("t5", 1, 32'h600, 32'h61, 1, 32'h604, 32'h62);
        waitValid("t5");
        memReadyEn = 1'b1;
        endCycle("t5");
        applyStimulus("t5", 1, 32'h608, 32'h63, 1, 32'h60C, 32'h64);
        checkOutput("t5_net_count", 64'(o_scb_count), 64'd3);
        checkOutput("t5_ready_at_3", 64'(o_commit_ready), 64'd0);
        for (int i = 0; i < 24; i++) begin
            if (modelCount <= SCB_NUM - 2 && $urandom_range(0, 1) == 1) begin
                int sel = $urandom_range(1, 3);
                applyStimulus("t5w", sel[0], $urandom, $urandom, sel[1], $urandom, $urandom);
            end else begin
                endCycle("t5w");
            end
        end
        waitDrain("t5");

        // Forwarding: same address twice, youngest wins; stores in flight are invisible.
        memReadyEn = 1'b0;
        i_ld_lookup_addr = 32'h40;
        driveCommit(1, 32'h40, 32'h1, 1, 32'h40, 32'h2);
        #1;
        checkOutput("t6_push_invisible", 64'(o_fwd_hit), 64'd0);
        endCycle("t6");
        #1;
`ifdef STORE_FWD_EN
        checkOutput("t6_hit_40", 64'(o_fwd_hit), 64'd1);
        checkOutput("t6_data_40", 64'(o_fwd_data), 64'd2);
`else
        checkOutput("t6_hit_40", 64'(o_fwd_hit), 64'd0);
        checkOutput("t6_data_40", 64'(o_fwd_data), 64'd0);
`endif
        i_ld_lookup_addr = 32'h44;
        #1;
        checkOutput("t6_hit_44", 64'(o_fwd_hit), 64'd0);
        checkOutput("t6_data_44", 64'(o_fwd_data), 64'd0);

        // Fill to four with memory stalled, then overflow.
        @(negedge clk);
        checkOutput("t3_ready_at_2", 64'(o_commit_ready), 64'd1);
        applyStimulus("t3", 1, 32'h50, 32'h3, 1, 32'h60, 32'h4);
        checkOutput("t3_full_count", 64'(o_scb_count), 64'd4);
        checkOutput("t3_ready_full", 64'(o_commit_ready), 64'd0);
        i_ld_lookup_addr = 32'h60;
        #1;
`ifdef STORE_FWD_EN
        checkOutput("t3_fwd_60", 64'(o_fwd_data), 64'd4);
`else
        checkOutput("t3_fwd_60", 64'(o_fwd_data), 64'd0);
`endif
        @(negedge clk);
        applyStimulus("t3", 1, 32'h70, 32'h5, 0, 0, 0);
        checkOutput("t3_overflow", 64'(o_overflow_err), 64'd1);
        checkOutput("t3_count_kept", 64'(o_scb_count), 64'd4);
        memReadyEn = 1'b1;
        waitDrain("t3");
        checkOutput("t3_overflow_sticky", 64'(o_overflow_err), 64'd1);
        applyReset();

        // Reset while waiting for an ack abandons the request.
        autoAck = 1'b0;
        applyStimulus("t7", 1, 32'h500, 32'h55, 0, 0, 0);
        waitValid("t7");
        endCycle("t7");
        checkOutput("t7_in_wait_ack", 64'(o_mem_req_valid), 64'd0);
        memReadyEn = 1'b0;
        applyReset();
        checkOutput("t7_count_zero", 64'(o_scb_count), 64'd0);
        endCycle("t7");
        checkOutput("t7_still_idle", 64'(o_mem_req_valid), 64'd0);
        autoAck = 1'b1;
        memReadyEn = 1'b1;
        applyStimulus("t7r", 1, 32'h700, 32'h77, 1, 32'h704, 32'h78);
        waitDrain("t7r");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
